// File: rtl/floor_pkg.sv
// floor_pkg: shared constants, reset layout and scroll-profile helper for the
// floor platform field (floor_field and its sub-blocks).
package floor_pkg;

  localparam int unsigned NUM_FLOORS = 8;
  localparam int unsigned POS_W      = 10;
  localparam int unsigned TG_W       = 9;
  localparam int unsigned SCORE_W    = 16;
  localparam int unsigned SCREEN_BOT = 480;
  localparam int unsigned FLOOR_W    = 40;
  localparam int unsigned X_MAX      = 599;
  localparam int unsigned SPAWN_GAP  = 60;

  // Jump-decimation profile boundaries on time_gap
  localparam int unsigned PROF_B1 = 80;
  localparam int unsigned PROF_B2 = 160;
  localparam int unsigned PROF_B3 = 240;
  localparam int unsigned PROF_B4 = 320;

  typedef logic [POS_W-1:0] floor_pos_t;

  localparam floor_pos_t RESET_X [NUM_FLOORS] = '{
    10'd300, 10'd80, 10'd460, 10'd200, 10'd540, 10'd20, 10'd360, 10'd140
  };

  localparam floor_pos_t RESET_Y [NUM_FLOORS] = '{
    10'd440, 10'd380, 10'd320, 10'd260, 10'd200, 10'd140, 10'd80, 10'd20
  };

  // True when the slime's jump phase moves one pixel this frame step
  function automatic logic scroll_phase(input logic [TG_W-1:0] tg);
    logic hit;
    hit = 1'b0;
    if (tg == '0)                      hit = 1'b0;
    else if (tg < TG_W'(PROF_B1))      hit = 1'b1;
    else if (tg < TG_W'(PROF_B2))      hit = (tg[0]   == 1'b0);
    else if (tg < TG_W'(PROF_B3))      hit = (tg[1:0] == 2'b00);
    else if (tg < TG_W'(PROF_B4))      hit = (tg[2:0] == 3'b000);
    return hit;
  endfunction

endpackage

// File: rtl/floor_field_if.sv
// floor_field_if: slime/floor link. master = floor producer (floor_field),
// slave = slime movement side, which supplies frame step and jump status
// and consumes platform positions, enables, score and scroll flag.
interface floor_field_if;
  import floor_pkg::*;

  logic                 clk_vga;
  logic [TG_W-1:0]      time_gap;
  logic                 hit_ceiling;
  floor_pos_t           floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3;
  floor_pos_t           floor_pos_x4, floor_pos_x5, floor_pos_x6, floor_pos_x7;
  floor_pos_t           floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3;
  floor_pos_t           floor_pos_y4, floor_pos_y5, floor_pos_y6, floor_pos_y7;
  logic [NUM_FLOORS-1:0] enable;
  logic [SCORE_W-1:0]   score;
  logic                 scroll;

  modport master (
    input  clk_vga, time_gap, hit_ceiling,
    output floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
           floor_pos_x4, floor_pos_x5, floor_pos_x6, floor_pos_x7,
           floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
           floor_pos_y4, floor_pos_y5, floor_pos_y6, floor_pos_y7,
           enable, score, scroll
  );

  modport slave (
    output clk_vga, time_gap, hit_ceiling,
    input  floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
           floor_pos_x4, floor_pos_x5, floor_pos_x6, floor_pos_x7,
           floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
           floor_pos_y4, floor_pos_y5, floor_pos_y6, floor_pos_y7,
           enable, score, scroll
  );

endinterface

// File: rtl/floor_lfsr.sv
// floor_lfsr: 10-bit Fibonacci LFSR (taps 10,7) for platform spawn x.
// Ports: clk, rst_n (async active-low), step_en (advance one state),
//        value (current register contents).
module floor_lfsr
  import floor_pkg::*;
#(
  parameter logic [POS_W-1:0] SEED = 10'h2A5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  output logic [POS_W-1:0] value
);

  logic [POS_W-1:0] lfsr_q, lfsr_d;

  // Shift left, feedback from bits 10 and 7 (1-based)
  always_comb begin
    lfsr_d = lfsr_q;
    if (step_en) lfsr_d = {lfsr_q[POS_W-2:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/floor_field.sv
// floor_field: owns the 8 floor platform slots. Scrolls platforms down while
// the slime is pinned at the ceiling, retires platforms at the screen bottom,
// spawns new ones at the top at pseudo-random x and counts spawns.
// Ports: clk, rst_n (async active-low), bus (floor_field_if.master):
//   in  clk_vga, time_gap, hit_ceiling
//   out floor_pos_x0..7, floor_pos_y0..7, enable, score, scroll (registered)
// Build option: FLOOR_DRIFT_EN adds horizontal drift of enabled platforms
// every 4th frame step (odd slots right, even slots left, wrapping).
module floor_field
  import floor_pkg::*;
#(
  parameter int unsigned      SPAWN_GAP  = 60,
  parameter int unsigned      FLOOR_W    = 40,
  parameter int unsigned      SCREEN_BOT = 480,
  parameter logic [POS_W-1:0] LFSR_SEED  = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst_n,
  floor_field_if.master bus
);

  localparam int unsigned X_LIM = 639 - FLOOR_W;
  localparam int unsigned CNT_W = $clog2(SPAWN_GAP + 1);

  floor_pos_t            x_q [NUM_FLOORS];
  floor_pos_t            x_d [NUM_FLOORS];
  floor_pos_t            y_q [NUM_FLOORS];
  floor_pos_t            y_d [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] en_q, en_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic                  scroll_q, scroll_d;
  logic [CNT_W-1:0]      spawn_cnt_q, spawn_cnt_d;

  logic                  step_c;
  logic                  pending_c;
  logic                  free_c;
  logic                  spawn_c;
  logic [2:0]            sel_c;
  floor_pos_t            lfsr_val;
  floor_pos_t            xr_c;

  floor_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_en (bus.clk_vga),
    .value   (lfsr_val)
  );

`ifdef FLOOR_DRIFT_EN
  logic [1:0] drift_cnt_q, drift_cnt_d;
  logic       drift_c;

  // Free-running phase counter; drift fires on every 4th frame step
  always_comb begin
    drift_cnt_d = drift_cnt_q;
    if (bus.clk_vga) drift_cnt_d = drift_cnt_q + 2'd1;
    drift_c = bus.clk_vga && (drift_cnt_q == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drift_cnt_q <= 2'd0;
    else        drift_cnt_q <= drift_cnt_d;
  end
`endif

  // Lowest-index free slot, judged on the pre-edge enable vector
  always_comb begin
    sel_c  = 3'd0;
    free_c = ~&en_q;
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (!en_q[i]) sel_c = 3'(i);
    end
  end

  // Step / spawn decode; lfsr values 600..1023 fold down by 512
  always_comb begin
    step_c    = bus.clk_vga && bus.hit_ceiling && scroll_phase(bus.time_gap);
    pending_c = (spawn_cnt_q == CNT_W'(SPAWN_GAP));
    spawn_c   = bus.clk_vga && pending_c && free_c;
    xr_c      = (lfsr_val >= POS_W'(X_LIM + 1)) ? (lfsr_val - 10'd512) : lfsr_val;
  end

  // Next-state for slots, counters and flags
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    en_d        = en_q;
    score_d     = score_q;
    spawn_cnt_d = spawn_cnt_q;
    scroll_d    = scroll_q;

    if (bus.clk_vga) scroll_d = step_c;

    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (step_c && en_q[i]) begin
        y_d[i] = y_q[i] + 10'd1;
        if ((y_q[i] + 10'd1) == POS_W'(SCREEN_BOT)) en_d[i] = 1'b0;
      end
`ifdef FLOOR_DRIFT_EN
      if (drift_c && en_q[i]) begin
        if (i % 2 == 1) x_d[i] = (x_q[i] == POS_W'(X_LIM)) ? '0 : x_q[i] + 10'd1;
        else            x_d[i] = (x_q[i] == '0) ? POS_W'(X_LIM) : x_q[i] - 10'd1;
      end
`endif
    end

    if (spawn_c) begin
      y_d[sel_c]  = '0;
      x_d[sel_c]  = xr_c;
      en_d[sel_c] = 1'b1;
      spawn_cnt_d = '0;
      score_d     = (score_q == '1) ? score_q : score_q + 16'd1;
    end else if (step_c && !pending_c) begin
      spawn_cnt_d = spawn_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= RESET_X;
      y_q         <= RESET_Y;
      en_q        <= '1;
      score_q     <= '0;
      scroll_q    <= 1'b0;
      spawn_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      en_q        <= en_d;
      score_q     <= score_d;
      scroll_q    <= scroll_d;
      spawn_cnt_q <= spawn_cnt_d;
    end
  end

  assign bus.floor_pos_x0 = x_q[0];
  assign bus.floor_pos_x1 = x_q[1];
  assign bus.floor_pos_x2 = x_q[2];
  assign bus.floor_pos_x3 = x_q[3];
  assign bus.floor_pos_x4 = x_q[4];
  assign bus.floor_pos_x5 = x_q[5];
  assign bus.floor_pos_x6 = x_q[6];
  assign bus.floor_pos_x7 = x_q[7];
  assign bus.floor_pos_y0 = y_q[0];
  assign bus.floor_pos_y1 = y_q[1];
  assign bus.floor_pos_y2 = y_q[2];
  assign bus.floor_pos_y3 = y_q[3];
  assign bus.floor_pos_y4 = y_q[4];
  assign bus.floor_pos_y5 = y_q[5];
  assign bus.floor_pos_y6 = y_q[6];
  assign bus.floor_pos_y7 = y_q[7];
  assign bus.enable       = en_q;
  assign bus.score        = score_q;
  assign bus.scroll       = scroll_q;

endmodule

// File: tb/tb_floor_field.sv
// tb_floor_field: directed stimulus for floor_field with a reference model;
// each frame step pushes the predicted post-edge state into a queue, which is
// popped and compared once the DUT edge has happened.
module tb_floor_field;
  import floor_pkg::*;

  typedef struct packed {
    logic [7:0][9:0] y;
    logic [7:0][9:0] x;
    logic [7:0]      en;
    logic [15:0]     score;
    logic            scroll;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  floor_field_if bus ();

  floor_field dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [9:0] obs_x [8];
  logic [9:0] obs_y [8];
  assign obs_x[0] = bus.floor_pos_x0;
  assign obs_x[1] = bus.floor_pos_x1;
  assign obs_x[2] = bus.floor_pos_x2;
  assign obs_x[3] = bus.floor_pos_x3;
  assign obs_x[4] = bus.floor_pos_x4;
  assign obs_x[5] = bus.floor_pos_x5;
  assign obs_x[6] = bus.floor_pos_x6;
  assign obs_x[7] = bus.floor_pos_x7;
  assign obs_y[0] = bus.floor_pos_y0;
  assign obs_y[1] = bus.floor_pos_y1;
  assign obs_y[2] = bus.floor_pos_y2;
  assign obs_y[3] = bus.floor_pos_y3;
  assign obs_y[4] = bus.floor_pos_y4;
  assign obs_y[5] = bus.floor_pos_y5;
  assign obs_y[6] = bus.floor_pos_y6;
  assign obs_y[7] = bus.floor_pos_y7;

  int n_total = 0;
  int n_pass  = 0;
  snap_t sb_q[$];

  // Reference model state
  int         m_y [8];
  int         m_x [8];
  logic [7:0] m_en;
  int         m_score;
  int         m_cnt;
  logic [9:0] m_lfsr;
  logic       m_scroll;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    int ry [8] = '{440, 380, 320, 260, 200, 140, 80, 20};
    int rx [8] = '{300, 80, 460, 200, 540, 20, 360, 140};
    for (int i = 0; i < 8; i++) begin
      m_y[i] = ry[i];
      m_x[i] = rx[i];
    end
    m_en = 8'hFF; m_score = 0; m_cnt = 0; m_lfsr = 10'h2A5; m_scroll = 1'b0;
  endtask

  function automatic snap_t snap();
    snap_t s;
    for (int i = 0; i < 8; i++) begin
      s.y[i] = 10'(m_y[i]);
      s.x[i] = 10'(m_x[i]);
    end
    s.en = m_en; s.score = 16'(m_score); s.scroll = m_scroll;
    return s;
  endfunction

  // Advance the model by one clock edge given the currently driven inputs
  task automatic model_edge(input logic vga, input logic hit, input int tg);
    int         stride;
    logic       step;
    logic [7:0] pre_en;
    int         xr;
    if (!vga) return;
    if (tg < 80) stride = 1;
    else if (tg < 160) stride = 2;
    else if (tg < 240) stride = 4;
    else if (tg < 320) stride = 8;
    else stride = 0;
    step   = hit && (tg != 0) && (stride != 0) && ((tg % ((stride == 0) ? 1 : stride)) == 0);
    pre_en = m_en;
    xr     = (m_lfsr >= 10'd600) ? int'(m_lfsr) - 512 : int'(m_lfsr);
    for (int i = 0; i < 8; i++) begin
      if (step && pre_en[i]) begin
        m_y[i] = m_y[i] + 1;
        if (m_y[i] == 480) m_en[i] = 1'b0;
      end
    end
    if (m_cnt == 60 && pre_en != 8'hFF) begin
      for (int i = 0; i < 8; i++) begin
        if (!pre_en[i]) begin
          m_y[i] = 0; m_x[i] = xr; m_en[i] = 1'b1;
          break;
        end
      end
      m_cnt = 0;
      if (m_score < 65535) m_score++;
    end else if (step && m_cnt < 60) begin
      m_cnt++;
    end
    m_scroll = step;
    m_lfsr   = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  endtask

  task automatic compare_snap(input snap_t e, input string ctx);
    check({ctx, ":enable"}, 32'(bus.enable), 32'(e.en));
    check({ctx, ":score"},  32'(bus.score),  32'(e.score));
    check({ctx, ":scroll"}, 32'(bus.scroll), 32'(e.scroll));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s:y%0d", ctx, i), 32'(obs_y[i]), 32'(e.y[i]));
      check($sformatf("%s:x%0d", ctx, i), 32'(obs_x[i]), 32'(e.x[i]));
    end
  endtask

  // One clock cycle with the given frame-step/jump inputs
  task automatic cyc(input logic vga, input logic hit, input int tg, input string ctx);
    snap_t e;
    @(negedge clk);
    bus.clk_vga     = vga;
    bus.hit_ceiling = hit;
    bus.time_gap    = 9'(tg);
    model_edge(vga, hit, tg);
    sb_q.push_back(snap());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare_snap(e, ctx);
    bus.clk_vga = 1'b0;
  endtask

  initial begin
    bus.clk_vga = 1'b0; bus.hit_ceiling = 1'b0; bus.time_gap = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    compare_snap(snap(), "reset");
    check("reset_y7", 32'(obs_y[7]), 32'd20);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 5, "tg5");
    check("after10_y0", 32'(obs_y[0]), 32'd450);
    check("after10_y7", 32'(obs_y[7]), 32'd30);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 5, "no_ceiling");
    check("no_ceiling_scroll", 32'(bus.scroll), 32'd0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 5, "vga_low");

    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 81, "tg81");
    check("tg81_y0", 32'(obs_y[0]), 32'd450);
    cyc(1'b1, 1'b1, 80, "tg80");
    check("tg80_y0", 32'(obs_y[0]), 32'd451);

    cyc(1'b1, 1'b1, 0,   "tg0");
    cyc(1'b1, 1'b1, 320, "tg320");
    cyc(1'b1, 1'b1, 161, "tg161");
    cyc(1'b1, 1'b1, 160, "tg160");
    cyc(1'b1, 1'b1, 244, "tg244");
    cyc(1'b1, 1'b1, 240, "tg240");
    cyc(1'b1, 1'b1, 319, "tg319");
    check("profile_y0", 32'(obs_y[0]), 32'd453);

    for (int k = 0; k < 27; k++) cyc(1'b1, 1'b1, 1, "to_retire");
    check("retire_y0",  32'(obs_y[0]), 32'd480);
    check("retire_en0", 32'(bus.enable[0]), 32'd0);
    check("retire_score", 32'(bus.score), 32'd0);

    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 1, "post_retire");
    check("frozen_y0", 32'(obs_y[0]), 32'd480);
    check("no_spawn_yet", 32'(bus.score), 32'd0);

    cyc(1'b1, 1'b1, 1, "spawn");
    check("spawn_y0",  32'(obs_y[0]), 32'd0);
    check("spawn_en0", 32'(bus.enable[0]), 32'd1);
    check("spawn_score", 32'(bus.score), 32'd1);
    check("spawn_x_range", 32'(obs_x[0] <= 10'd599), 32'd1);
    check("spawn_y1", 32'(obs_y[1]), 32'd441);

    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1, "post_spawn");
    check("post_spawn_y0", 32'(obs_y[0]), 32'd6);

    // Asynchronous reset asserted between clock edges
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_snap(snap(), "async_reset");
    check("async_reset_y0", 32'(obs_y[0]), 32'd440);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 2, "after_reset");
    check("after_reset_y0", 32'(obs_y[0]), 32'd444);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
